dsd9_bus_arbiter: RTL and testbench

Two-master arbiter for the DSD9 128-bit system bus. Shares the single slave-side bus (bootrom, scratchram, main memory, IOBridge, I/O) between the CPU (m0) and a second master such as DMA or a second hart (m1). Grants are round-robin and held for the whole cyc_i tenure. A bus-timeout watchdog returns an error to the owner when no slave acks, and latches the failing address.

---
 rtl/dsd9_bus_arbiter_if.sv | 65 ++++++
 rtl/dsd9_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_dsd9_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsd9_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dsd9_bus_arbiter_if
// Bundles every bus signal around the DSD9 two-master arbiter: the two
// master-side request/return groups (m0_*, m1_*), the shared slave-side bus
// (s_*), the one-hot grant and the captured timeout address.
//
// Modports:
//   master : arbiter view. Reads master requests and slave responses, drives
//            the shared bus, master returns, grant and err_adr_o.
//   slave  : environment view (masters + slaves). Mirror of master.
// ---------------------------------------------------------------------------
interface dsd9_bus_arbiter_if;
    // master 0
    logic         m0_cyc_i;
    logic         m0_stb_i;
    logic         m0_wr_i;
    logic [15:0]  m0_sel_i;
    logic [31:0]  m0_adr_i;
    logic [127:0] m0_dat_i;
    logic         m0_ack_o;
    logic         m0_err_o;
    logic [127:0] m0_dat_o;
    // master 1
    logic         m1_cyc_i;
    logic         m1_stb_i;
    logic         m1_wr_i;
    logic [15:0]  m1_sel_i;
    logic [31:0]  m1_adr_i;
    logic [127:0] m1_dat_i;
    logic         m1_ack_o;
    logic         m1_err_o;
    logic [127:0] m1_dat_o;
    // shared slave-side bus
    logic         s_cyc_o;
    logic         s_stb_o;
    logic         s_wr_o;
    logic [15:0]  s_sel_o;
    logic [31:0]  s_adr_o;
    logic [127:0] s_dat_o;
    logic         s_ack_i;
    logic [127:0] s_dat_i;
    // status
    logic [1:0]   gnt_o;
    logic [31:0]  err_adr_o;

    modport master (
        input  m0_cyc_i, m0_stb_i, m0_wr_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_cyc_i, m1_stb_i, m1_wr_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_wr_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output gnt_o, err_adr_o
    );

    modport slave (
        output m0_cyc_i, m0_stb_i, m0_wr_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_cyc_i, m1_stb_i, m1_wr_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_wr_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  gnt_o, err_adr_o
    );
endinterface

// File: rtl/dsd9_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dsd9_bus_arbiter
// Two-master round-robin arbiter for the 128-bit DSD9 system bus. A grant is
// held for the owner's whole cyc tenure; one IDLE cycle always separates two
// tenures. A watchdog raises a one-cycle error to the owner after TIMEOUT
// strobed cycles without an ack and records the failing address.
//
// Ports:
//   clk_i : system clock
//   rst_i : asynchronous active-low reset
//   bus   : dsd9_bus_arbiter_if.master (m0_*, m1_*, s_*, gnt_o, err_adr_o)
//
// Parameters:
//   TIMEOUT : strobed cycles without ack before a bus error (2..65535)
// ---------------------------------------------------------------------------
module dsd9_bus_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    dsd9_bus_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic         last_q, last_d;      // master granted most recently
    logic [15:0]  tmo_q, tmo_d;
    logic [31:0]  err_adr_q, err_adr_d;

    logic         own0, own1;
    logic         s_cyc, s_stb, s_wr;
    logic [15:0]  s_sel;
    logic [31:0]  s_adr;
    logic [127:0] s_dat;
    logic         expire;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    // Shared bus: AND-OR mux of the owner's signals, all-zero in IDLE.
    always_comb begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_wr  = 1'b0;
        s_sel = '0;
        s_adr = '0;
        s_dat = '0;
        if (own0) begin
            s_cyc = bus.m0_cyc_i;
            s_stb = bus.m0_stb_i;
            s_wr  = bus.m0_wr_i;
            s_sel = bus.m0_sel_i;
            s_adr = bus.m0_adr_i;
            s_dat = bus.m0_dat_i;
        end else if (own1) begin
            s_cyc = bus.m1_cyc_i;
            s_stb = bus.m1_stb_i;
            s_wr  = bus.m1_wr_i;
            s_sel = bus.m1_sel_i;
            s_adr = bus.m1_adr_i;
            s_dat = bus.m1_dat_i;
        end
    end

    // An ack arriving on the expiry cycle suppresses the error.
    assign expire = (own0 | own1) & s_stb & ~bus.s_ack_i & (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        err_adr_d = err_adr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    // Tie: the master that did not win last time goes first.
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (bus.m0_cyc_i) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (bus.m1_cyc_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0:    if (!bus.m0_cyc_i) state_d = IDLE;
            OWN1:    if (!bus.m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || !s_stb || bus.s_ack_i || expire) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        if (expire) begin
            err_adr_d = s_adr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            tmo_q     <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign bus.s_cyc_o   = s_cyc;
    assign bus.s_stb_o   = s_stb;
    assign bus.s_wr_o    = s_wr;
    assign bus.s_sel_o   = s_sel;
    assign bus.s_adr_o   = s_adr;
    assign bus.s_dat_o   = s_dat;

    assign bus.m0_ack_o  = bus.s_ack_i & own0;
    assign bus.m1_ack_o  = bus.s_ack_i & own1;
    assign bus.m0_err_o  = expire & own0;
    assign bus.m1_err_o  = expire & own1;
    assign bus.m0_dat_o  = own0 ? bus.s_dat_i : '0;
    assign bus.m1_dat_o  = own1 ? bus.s_dat_i : '0;

    assign bus.gnt_o     = {own1, own0};
    assign bus.err_adr_o = err_adr_q;

endmodule

// File: tb/tb_dsd9_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dsd9_bus_arbiter
// Drives random and directed traffic into dsd9_bus_arbiter and compares every
// output each cycle against a transaction-level model of the arbiter
// (owner / last-winner / strobes-waited bookkeeping).
// ---------------------------------------------------------------------------
module tb_dsd9_bus_arbiter;

    localparam int TIMEOUT = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    dsd9_bus_arbiter_if bus ();

    dsd9_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: owner -1 = nobody, 0/1 = master index.
    int          owner;
    int          last_m;
    int          waited;       // consecutive unacked strobe cycles this tenure
    logic [31:0] m_err_adr;
    bit          err_now;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic reset_model();
        owner     = -1;
        last_m    = 1;
        waited    = 0;
        m_err_adr = '0;
    endtask

    task automatic set_master(input int m, input bit cyc, input bit stb, input bit wr,
                              input logic [15:0] sel, input logic [31:0] adr,
                              input logic [127:0] dat);
        if (m == 0) begin
            bus.m0_cyc_i = cyc; bus.m0_stb_i = stb; bus.m0_wr_i = wr;
            bus.m0_sel_i = sel; bus.m0_adr_i = adr; bus.m0_dat_i = dat;
        end else begin
            bus.m1_cyc_i = cyc; bus.m1_stb_i = stb; bus.m1_wr_i = wr;
            bus.m1_sel_i = sel; bus.m1_adr_i = adr; bus.m1_dat_i = dat;
        end
    endtask

    // Compare all outputs against what the model predicts for this cycle.
    task automatic compare_all();
        bit           ecyc, estb, ewr;
        logic [15:0]  esel;
        logic [31:0]  eadr;
        logic [127:0] edat;
        ecyc = 0; estb = 0; ewr = 0; esel = '0; eadr = '0; edat = '0;
        if (owner == 0) begin
            ecyc = bus.m0_cyc_i; estb = bus.m0_stb_i; ewr = bus.m0_wr_i;
            esel = bus.m0_sel_i; eadr = bus.m0_adr_i; edat = bus.m0_dat_i;
        end else if (owner == 1) begin
            ecyc = bus.m1_cyc_i; estb = bus.m1_stb_i; ewr = bus.m1_wr_i;
            esel = bus.m1_sel_i; eadr = bus.m1_adr_i; edat = bus.m1_dat_i;
        end
        // The TIMEOUT-th unacked strobe cycle in a row raises the error.
        err_now = (owner >= 0) && estb && !bus.s_ack_i && (waited + 1 == TIMEOUT);

        chk("s_cyc", bus.s_cyc_o, ecyc);
        chk("s_stb", bus.s_stb_o, estb);
        chk("s_wr",  bus.s_wr_o,  ewr);
        chk("s_sel", bus.s_sel_o, esel);
        chk("s_adr", bus.s_adr_o, eadr);
        chk("s_dat", bus.s_dat_o, edat);
        chk("gnt",   bus.gnt_o, (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
        chk("m0_ack", bus.m0_ack_o, (owner == 0) && bus.s_ack_i);
        chk("m1_ack", bus.m1_ack_o, (owner == 1) && bus.s_ack_i);
        chk("m0_err", bus.m0_err_o, (owner == 0) && err_now);
        chk("m1_err", bus.m1_err_o, (owner == 1) && err_now);
        chk("m0_dat", bus.m0_dat_o, (owner == 0) ? bus.s_dat_i : 128'd0);
        chk("m1_dat", bus.m1_dat_o, (owner == 1) ? bus.s_dat_i : 128'd0);
        chk("err_adr", bus.err_adr_o, m_err_adr);
    endtask

    // Advance the model across one rising edge using the inputs held stable.
    task automatic update_model();
        bit c0, c1, ostb, ocyc;
        c0 = bus.m0_cyc_i;
        c1 = bus.m1_cyc_i;
        if (owner < 0) begin
            if (c0 && c1) owner = (last_m == 0) ? 1 : 0;
            else if (c0)  owner = 0;
            else if (c1)  owner = 1;
            if (owner >= 0) last_m = owner;
            waited = 0;
        end else begin
            ocyc = (owner == 0) ? c0 : c1;
            ostb = (owner == 0) ? bus.m0_stb_i : bus.m1_stb_i;
            if (err_now) begin
                m_err_adr = (owner == 0) ? bus.m0_adr_i : bus.m1_adr_i;
                waited    = 0;
            end else if (ostb && !bus.s_ack_i) begin
                waited++;
            end else begin
                waited = 0;
            end
            if (!ocyc) begin
                owner  = -1;
                waited = 0;
            end
        end
    endtask

    // Called at a falling edge with inputs already set; ends at the next one.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk_i);
        update_model();
        @(negedge clk_i);
    endtask

    task automatic rand_inputs(input int drop_div, input int stb_pct, input int ack_pct);
        bit c0, c1;
        c0 = bus.m0_cyc_i;
        c1 = bus.m1_cyc_i;
        if (c0) c0 = ($urandom_range(drop_div - 1) != 0); else c0 = ($urandom_range(2) == 0);
        if (c1) c1 = ($urandom_range(drop_div - 1) != 0); else c1 = ($urandom_range(2) == 0);
        set_master(0, c0, c0 && ($urandom_range(99) < stb_pct), $urandom_range(1) == 1,
                   16'($urandom), $urandom, rand128());
        set_master(1, c1, c1 && ($urandom_range(99) < stb_pct), $urandom_range(1) == 1,
                   16'($urandom), $urandom, rand128());
        bus.s_ack_i = ($urandom_range(99) < ack_pct);
        bus.s_dat_i = rand128();
    endtask

    initial begin
        reset_model();
        set_master(0, 0, 0, 0, '0, '0, '0);
        set_master(1, 0, 0, 0, '0, '0, '0);
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;

        // Reset state, even with requests pending.
        repeat (2) @(negedge clk_i);
        bus.m0_cyc_i = 1'b1;
        bus.m1_cyc_i = 1'b1;
        #1;
        chk("rst_gnt", bus.gnt_o, 2'b00);
        chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
        chk("rst_err_adr", bus.err_adr_o, 32'd0);
        bus.m0_cyc_i = 1'b0;
        bus.m1_cyc_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        // m0 single read, slave acks on the second strobe cycle.
        set_master(0, 1, 1, 0, 16'hFFFF, 32'hFFFC0000, '0);
        step();
        step();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 128'h0000_DEAD;
        #1;
        chk("rd_gnt", bus.gnt_o, 2'b01);
        chk("rd_ack", bus.m0_ack_o, 1'b1);
        chk("rd_dat", bus.m0_dat_o, 128'h0000_DEAD);
        chk("rd_m1_dat", bus.m1_dat_o, 128'd0);
        step();
        bus.s_ack_i = 1'b0;
        set_master(0, 0, 0, 0, '0, '0, '0);
        step();
        step();

        // Timeout on m1: error on the 8th unacked strobe cycle.
        set_master(1, 1, 1, 0, 16'hFFFF, 32'hFFDC0100, '0);
        step();
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i == TIMEOUT) begin
                #1;
                chk("to_m1_err", bus.m1_err_o, 1'b1);
                chk("to_m0_err", bus.m0_err_o, 1'b0);
            end
            step();
        end
        chk("to_err_adr", bus.err_adr_o, 32'hFFDC0100);
        chk("to_gnt_held", bus.gnt_o, 2'b10);
        // Ack on the expiry cycle wins over the error.
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i == TIMEOUT) begin
                bus.s_ack_i = 1'b1;
                bus.m1_adr_i = 32'h1234_5678;
                #1;
                chk("aw_ack", bus.m1_ack_o, 1'b1);
                chk("aw_err", bus.m1_err_o, 1'b0);
            end
            step();
        end
        bus.s_ack_i = 1'b0;
        chk("aw_err_adr", bus.err_adr_o, 32'hFFDC0100);

        // Asynchronous reset in the middle of an m1 tenure.
        step();
        #2;
        bus.s_ack_i = 1'b1;
        rst_i = 1'b0;
        #1;
        chk("ar_s_cyc", bus.s_cyc_o, 1'b0);
        chk("ar_gnt", bus.gnt_o, 2'b00);
        chk("ar_m1_ack", bus.m1_ack_o, 1'b0);
        chk("ar_m1_err", bus.m1_err_o, 1'b0);
        reset_model();
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.s_ack_i = 1'b0;
        set_master(0, 1, 0, 0, '0, 32'h100, '0);
        step();
        #1;
        chk("ar_first_m0", bus.gnt_o, 2'b01);
        set_master(0, 0, 0, 0, '0, '0, '0);
        step();
        #1;
        chk("ar_dead_idle", bus.gnt_o, 2'b00);
        step();
        #1;
        chk("ar_then_m1", bus.gnt_o, 2'b10);
        set_master(1, 0, 0, 0, '0, '0, '0);
        step();
        step();

        // Randomized traffic: mixed acks, then slow slaves provoking timeouts.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(8, 60, 40);
            step();
        end
        for (int i = 0; i < 400; i++) begin
            rand_inputs(32, 100, 3);
            step();
        end

        // Idle bus with random payloads: shared bus must stay all-zero.
        set_master(0, 0, 0, 0, '0, '0, '0);
        set_master(1, 0, 0, 0, '0, '0, '0);
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            set_master(0, 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                       16'($urandom), $urandom, rand128());
            set_master(1, 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                       16'($urandom), $urandom, rand128());
            bus.s_ack_i = $urandom_range(1) == 1;
            bus.s_dat_i = rand128();
            #1;
            chk("idle_s_all", {bus.s_cyc_o, bus.s_stb_o, bus.s_wr_o, bus.s_sel_o,
                               bus.s_adr_o, bus.s_dat_o[63:0]}, '0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
